// File: rtl/div_pkg.sv
// Shared constants, state encoding and sign helpers for the 16-bit sequential divider.
package div_pkg;

  localparam int DW        = 16;
  localparam int DIV_ITERS = 16;
  localparam int CNT_W     = 5;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Two's complement negation, modulo 2^16.
  function automatic logic [DW-1:0] neg16(input logic [DW-1:0] v);
    return (~v) + 16'd1;
  endfunction

  // Magnitude of a signed value; abs(0x8000) stays 0x8000 as an unsigned magnitude.
  function automatic logic [DW-1:0] abs16(input logic [DW-1:0] v);
    return v[DW-1] ? neg16(v) : v;
  endfunction

endpackage

// File: rtl/sub16.sv
// Combinational 16-bit subtractor with borrow-out, built on a 4x4 carry-lookahead adder
// (a + ~b + 1). An extra MSB of the minuend extends it to a 17-bit trial subtract.
module sub16
  import div_pkg::*;
(
  input  logic [DW-1:0] i_a,
  input  logic          i_a_msb,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_diff,
  output logic          o_borrow
);

  localparam int NGRP = DW / 4;

  logic [DW-1:0]   w_bn;
  logic [DW-1:0]   w_g;
  logic [DW-1:0]   w_p;
  logic [NGRP-1:0] w_grp_g;
  logic [NGRP-1:0] w_grp_p;
  logic [NGRP:0]   w_grp_c;
  logic            w_cin;

  assign w_cin = 1'b1;
  assign w_bn  = ~i_b;
  assign w_g   = i_a & w_bn;
  assign w_p   = i_a ^ w_bn;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [3:0] w_gg;
    logic [3:0] w_pp;
    logic [3:0] w_c;

    assign w_gg = w_g[gi*4 +: 4];
    assign w_pp = w_p[gi*4 +: 4];

    assign w_grp_g[gi] = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                       | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);
    assign w_grp_p[gi] = &w_pp;

    // In-group carries, fully expanded from the group carry-in.
    assign w_c[0] = w_grp_c[gi];
    assign w_c[1] = w_gg[0] | (w_pp[0] & w_grp_c[gi]);
    assign w_c[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_grp_c[gi]);
    assign w_c[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                  | (w_pp[2] & w_pp[1] & w_pp[0] & w_grp_c[gi]);

    assign o_diff[gi*4 +: 4] = w_pp ^ w_c;
  end

  // Group-level lookahead carries.
  assign w_grp_c[0] = w_cin;
  assign w_grp_c[1] = w_grp_g[0] | (w_grp_p[0] & w_cin);
  assign w_grp_c[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0]) | (w_grp_p[1] & w_grp_p[0] & w_cin);
  assign w_grp_c[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1]) | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & w_cin);
  assign w_grp_c[4] = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2]) | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & w_cin);

  // A set minuend MSB always covers a 16-bit subtrahend, so a borrow needs both
  // the MSB clear and no carry out of the 16-bit adder.
  assign o_borrow = (~i_a_msb) & (~w_grp_c[NGRP]);

endmodule

// File: rtl/div16_seq.sv
// Multi-cycle restoring 16-bit divider (DIV/DIVU) with start/busy/done handshake.
// Quotient feeds LO, remainder feeds HI; results hold until the next done.
module div16_seq
  import div_pkg::*;
#(
  parameter logic [DW-1:0] DIV0_QUOT = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_signed,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_rem;
  logic [DW-1:0]    r_quo;
  logic [DW-1:0]    r_dmag;
  logic             r_sgn_dd;
  logic             r_sgn_dv;
  logic             r_signed;
  logic             r_busy;
  logic             r_done;
  logic [DW-1:0]    r_quot;
  logic [DW-1:0]    r_remd;
  logic             r_dbz;

  logic [DW-1:0]    w_shift_rem;
  logic             w_shift_msb;
  logic [DW-1:0]    w_diff;
  logic             w_borrow;
  logic [DW-1:0]    w_quo_fix;
  logic [DW-1:0]    w_rem_fix;

  // Partial remainder after shifting {rem, quo} left by one; the bit leaving rem is the 17th bit.
  assign w_shift_rem = {r_rem[DW-2:0], r_quo[DW-1]};
  assign w_shift_msb = r_rem[DW-1];

  sub16 u_sub16 (
    .i_a      (w_shift_rem),
    .i_a_msb  (w_shift_msb),
    .i_b      (r_dmag),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // Sign fixup: quotient negative when operand signs differ, remainder follows the dividend.
  assign w_quo_fix = (r_signed & (r_sgn_dd ^ r_sgn_dv)) ? neg16(r_quo) : r_quo;
  assign w_rem_fix = (r_signed & r_sgn_dd) ? neg16(r_rem) : r_rem;

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remd;
  assign div_by_zero = r_dbz;

  // Divider FSM: operand capture, one restoring iteration per clock, sign fixup and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rem    <= 16'd0;
      r_quo    <= 16'd0;
      r_dmag   <= 16'd0;
      r_sgn_dd <= 1'b0;
      r_sgn_dv <= 1'b0;
      r_signed <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quot   <= 16'd0;
      r_remd   <= 16'd0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (divisor == 16'd0) begin
              // Divide-by-zero answers directly from IDLE without ever going busy.
              r_done <= 1'b1;
              r_quot <= DIV0_QUOT;
              r_remd <= dividend;
              r_dbz  <= 1'b1;
            end else begin
              r_quo    <= is_signed ? abs16(dividend) : dividend;
              r_dmag   <= is_signed ? abs16(divisor) : divisor;
              r_sgn_dd <= is_signed & dividend[DW-1];
              r_sgn_dv <= is_signed & divisor[DW-1];
              r_signed <= is_signed;
              r_rem    <= 16'd0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= ST_CALC;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_rem <= w_borrow ? w_shift_rem : w_diff;
          r_quo <= {r_quo[DW-2:0], ~w_borrow};
          if (r_cnt == LAST_ITER) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_FIX: begin
          r_quot  <= w_quo_fix;
          r_remd  <= w_rem_fix;
          r_dbz   <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
